// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, sequencer state encoding and HI/LO mux select
// values for the mult/div sequencer.
// Optional feature macro (used by muldiv_sequencer): MULDIV_EARLY_DZ_EN
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_DIVM = 2'b10,
        OP_ILL  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_WRITE = 3'd3,
        S_EXC   = 3'd4
    } state_e;

    localparam logic HILO_SEL_DIV  = 1'b0;
    localparam logic HILO_SEL_MULT = 1'b1;

    // True for both divide flavours (A/B and B/MDR)
    function automatic logic is_div_op(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVM);
    endfunction

endpackage

// File: rtl/muldiv_cnt.sv
// muldiv_cnt: loadable down-counter with zero flag. A decrement request at
// zero is ignored so the count never wraps.
module muldiv_cnt
    import muldiv_pkg::*;
#(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load has priority, decrement only while nonzero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle sequencer for the iterative mult/div units
// and the HI/LO register pair. Accepts one start pulse with an op code,
// pulses the unit init, waits the iteration count, then either loads HI/LO
// (done) or reports a divide-by-zero exception.
// Optional feature macro: MULDIV_EARLY_DZ_EN -- detect a zero divisor in INIT
// from divisor_in and abort before the divider is started.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 32,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        div_zero_in,
    input  logic [31:0] divisor_in,
    output logic        busy,
    output logic        done,
    output logic        div_zero_exc,
    output logic        mult_init,
    output logic        div_init,
    output logic        div_src_sel,
    output logic        hilo_sel,
    output logic        hl_load
);

    state_e state_q, state_d;
    op_e    op_q, op_d;
    op_e    op_in;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic exc_q, exc_d;
    logic mult_init_q, mult_init_d;
    logic div_init_q, div_init_d;
    logic src_sel_q, src_sel_d;
    logic hilo_sel_q, hilo_sel_d;
    logic hl_load_q, hl_load_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_zero;

    assign op_in = op_e'(op);

    // Iteration counter: loaded in INIT, decremented through RUN
    muldiv_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .dec     (cnt_dec),
        .load_val(cnt_load_val),
        .count   (cnt_value),
        .zero    (cnt_zero)
    );

    // Next-state and next-output decode; outputs are registered so each one
    // is set on the same edge that enters the state it belongs to
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        exc_d        = 1'b0;
        mult_init_d  = 1'b0;
        div_init_d   = 1'b0;
        src_sel_d    = src_sel_q;
        hilo_sel_d   = hilo_sel_q;
        hl_load_d    = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = (op_q == OP_MULT) ? CNT_W'(MULT_CYCLES - 1)
                                         : CNT_W'(DIV_CYCLES - 1);

        unique case (state_q)
            S_IDLE: begin
                if (start && (op_in != OP_ILL)) begin
                    state_d     = S_INIT;
                    op_d        = op_in;
                    busy_d      = 1'b1;
                    mult_init_d = (op_in == OP_MULT);
                    div_init_d  = is_div_op(op_in);
                    src_sel_d   = (op_in == OP_DIVM);
                    hilo_sel_d  = (op_in == OP_MULT) ? HILO_SEL_MULT : HILO_SEL_DIV;
                end
            end

            S_INIT: begin
                cnt_load = 1'b1;
                state_d  = S_RUN;
`ifdef MULDIV_EARLY_DZ_EN
                if (is_div_op(op_q) && (divisor_in == '0)) begin
                    cnt_load = 1'b0;
                    state_d  = S_EXC;
                    exc_d    = 1'b1;
                end
`endif
            end

            S_RUN: begin
                cnt_dec = !cnt_zero;
                if (cnt_zero) begin
                    if (is_div_op(op_q) && div_zero_in) begin
                        state_d = S_EXC;
                        exc_d   = 1'b1;
                    end else begin
                        state_d   = S_WRITE;
                        done_d    = 1'b1;
                        hl_load_d = 1'b1;
                    end
                end
            end

            S_WRITE, S_EXC: begin
                state_d    = S_IDLE;
                busy_d     = 1'b0;
                src_sel_d  = 1'b0;
                hilo_sel_d = 1'b0;
            end

            default: begin
                state_d    = S_IDLE;
                busy_d     = 1'b0;
                src_sel_d  = 1'b0;
                hilo_sel_d = 1'b0;
            end
        endcase
    end

    // FSM state, latched op and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_MULT;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            exc_q       <= 1'b0;
            mult_init_q <= 1'b0;
            div_init_q  <= 1'b0;
            src_sel_q   <= 1'b0;
            hilo_sel_q  <= 1'b0;
            hl_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            exc_q       <= exc_d;
            mult_init_q <= mult_init_d;
            div_init_q  <= div_init_d;
            src_sel_q   <= src_sel_d;
            hilo_sel_q  <= hilo_sel_d;
            hl_load_q   <= hl_load_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign div_zero_exc = exc_q;
    assign mult_init    = mult_init_q;
    assign div_src_sel  = src_sel_q;
    assign hilo_sel     = hilo_sel_q;
    assign hl_load      = hl_load_q;

`ifdef MULDIV_EARLY_DZ_EN
    // divisor_in is only meaningful once div_src_sel has settled in INIT, so
    // the init pulse is gated there rather than decided a cycle earlier
    assign div_init = div_init_q && (divisor_in != '0);
`else
    assign div_init = div_init_q;
`endif

endmodule
